// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM encoding, register offsets and CTRL/STATUS bit positions
package imem_loader_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_REQ, S_DATA, S_DRAIN} state_t;
  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_CNT  = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_CSUM = 2'd3;
  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int ST_BUSY     = 0;
  localparam int ST_DONE     = 1;
  localparam int ST_ERROR    = 2;
  localparam int ST_ABORTED  = 3;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: Avalon-MM burst read channel (avm_rx_*)
//   master: drives address (byte), burstcount, read; receives waitrequest, readdata, readdatavalid
//   slave:  the opposite direction
interface imem_loader_if;
  logic [31:0] address;
  logic [11:0] burstcount;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;
  modport master (output address, burstcount, read, input waitrequest, readdata, readdatavalid);
  modport slave  (input address, burstcount, read, output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/imem_loader_regs.sv
// imem_loader_regs: Avalon slave register file (SRC_ADDR, WORD_COUNT, CTRL/STATUS, CHECKSUM)
//   avs_*            : register slave bus, readdata combinational from avs_address
//   busy..aborted    : status bits from the loader FSM; checksum from the loader
//   src_addr, word_count : programmed load parameters
//   start, abort     : single-cycle CTRL write strobes
module imem_loader_regs
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic        avs_read,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  input  logic        busy,
  input  logic        done,
  input  logic        error,
  input  logic        aborted,
  input  logic [31:0] checksum,
  output logic [31:0] src_addr,
  output logic [31:0] word_count,
  output logic        start,
  output logic        abort
);
  logic [29:0] src_q;
  logic [31:0] cnt_q;
  logic [31:0] status;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      src_q <= '0;
      cnt_q <= '0;
    end else if (avs_write && !busy) begin
      if (avs_address == REG_SRC) src_q <= avs_writedata[31:2];
      if (avs_address == REG_CNT) cnt_q <= avs_writedata;
    end
  assign src_addr   = {src_q, 2'b00};
  assign word_count = cnt_q;
  assign start = avs_write && avs_address == REG_CTRL && avs_writedata[CTRL_START];
  assign abort = avs_write && avs_address == REG_CTRL && avs_writedata[CTRL_ABORT];
  always_comb begin
    status = '0;
    status[ST_BUSY]    = busy;
    status[ST_DONE]    = done;
    status[ST_ERROR]   = error;
    status[ST_ABORTED] = aborted;
    avs_readdata = !avs_read                ? '0 :
                   avs_address == REG_SRC   ? src_addr :
                   avs_address == REG_CNT   ? cnt_q :
                   avs_address == REG_CTRL  ? status : checksum;
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: copies WORD_COUNT words from SRC_ADDR via Avalon bursts into instruction memory
//   clk, reset_n : clock, asynchronous active-low reset
//   avs_*        : register slave (see imem_loader_regs)
//   avm_rx       : Avalon-MM burst read master (imem_loader_if.master)
//   mem_*        : instruction memory write port, word addressed, registered
//   core_hold    : high while a load is in progress or its last write is pending
// Optional: define IMEM_LOADER_CHECKSUM_EN for a wrap-around sum of all written words.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MAX_BURST       = 16,
  parameter int IMEM_ADDR_WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [1:0]                 avs_address,
  input  logic                       avs_write,
  input  logic                       avs_read,
  input  logic [31:0]                avs_writedata,
  output logic [31:0]                avs_readdata,
  imem_loader_if.master              avm_rx,
  output logic                       mem_write,
  output logic [IMEM_ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]                mem_writedata,
  output logic [3:0]                 mem_byteenable,
  output logic                       core_hold
);
  state_t      state, state_nxt;
  logic [31:0] src_addr, word_count, idx, remaining, checksum;
  logic [11:0] beats_left, burst;
  logic        start, abort, busy, done, error, aborted;
  logic        too_big, beat, last, final_beat, wr;
  imem_loader_regs u_regs (
    .clk(clk), .reset_n(reset_n),
    .avs_address(avs_address), .avs_write(avs_write), .avs_read(avs_read),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .busy(busy), .done(done), .error(error), .aborted(aborted), .checksum(checksum),
    .src_addr(src_addr), .word_count(word_count), .start(start), .abort(abort)
  );
  assign remaining  = word_count - idx;
  assign burst      = remaining > 32'(MAX_BURST) ? 12'(MAX_BURST) : remaining[11:0];
  assign too_big    = {1'b0, word_count} > (33'd1 << IMEM_ADDR_WIDTH);
  assign beat       = avm_rx.readdatavalid;
  assign last       = beat && beats_left == 12'd1;
  assign final_beat = last && idx + 32'd1 == word_count;
  assign wr         = state == S_DATA && beat && !abort;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= state_nxt;
  // An abort that coincides with acceptance still owes the slave a full burst, hence DRAIN.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = start ? S_CHECK : S_IDLE;
      S_CHECK: state_nxt = (word_count == 32'd0 || too_big) ? S_IDLE : S_REQ;
      S_REQ:   state_nxt = !avm_rx.waitrequest ? (abort ? S_DRAIN : S_DATA) : (abort ? S_IDLE : S_REQ);
      S_DATA:  state_nxt = abort ? S_DRAIN : last ? (final_beat ? S_IDLE : S_REQ) : S_DATA;
      S_DRAIN: state_nxt = (beats_left == 12'd0 || last) ? S_IDLE : S_DRAIN;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_comb begin
    busy              = state != S_IDLE;
    avm_rx.read       = state == S_REQ;
    avm_rx.address    = avm_rx.read ? src_addr + {idx[29:0], 2'b00} : '0;
    avm_rx.burstcount = avm_rx.read ? burst : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      idx           <= '0;
      beats_left    <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
      aborted       <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
    end else begin
      mem_write <= wr;
      if (wr) begin
        mem_address   <= idx[IMEM_ADDR_WIDTH-1:0];
        mem_writedata <= avm_rx.readdata;
        idx           <= idx + 32'd1;
      end
      if (state == S_REQ && !avm_rx.waitrequest) beats_left <= burst;
      else if ((state == S_DATA || state == S_DRAIN) && beat && beats_left != 12'd0) beats_left <= beats_left - 12'd1;
      if (state == S_IDLE && start) begin
        idx     <= '0;
        done    <= 1'b0;
        error   <= 1'b0;
        aborted <= 1'b0;
      end
      if (state == S_CHECK) begin
        done  <= word_count == 32'd0;
        error <= too_big;
      end
      if (wr && final_beat) done <= 1'b1;
      if ((state == S_REQ || state == S_DRAIN) && state_nxt == S_IDLE) aborted <= 1'b1;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) checksum <= '0;
    else if (state == S_IDLE && start) checksum <= '0;
    else if (wr) checksum <= checksum + avm_rx.readdata;
`else
  assign checksum = '0;
`endif
  assign core_hold      = busy || mem_write;
  assign mem_byteenable = 4'hF;
endmodule
